uart_rx2: RTL and testbench

UART_RX2 -- requirements
Module: uart_rx2

---
 rtl/uart_rx2.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx2.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx2.sv
// uart_rx2: oversampling UART receiver with a 2-flop input synchronizer,
// 3-sample majority vote, optional parity, single-entry output register
// with valid/ready handshake, and a per-data-bit strobe for a serial CRC.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a 1->0 edge on the synchronized line
// S_START  | half a bit period into the start bit; rejects glitches
// S_DATA   | sampling data bits, LSB first
// S_PARITY | sampling and checking the parity bit
// S_STOP   | sampling the stop bit; hand the word to the output register
module uart_rx2 #(
  parameter int CLKS_PER_BIT = 12,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 crc_din,
  output logic                 crc_en
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic                 rx_meta_q;
  logic                 rs_q;
  logic                 rs_prev_q;
  logic                 rs_prev2_q;
  logic [1:0]           settle_q;

  state_e               state_q;
  logic [TW-1:0]        tick_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc_q;
  logic                 perr_pend_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 crc_din_q;
  logic                 crc_en_q;

  logic rs_fall;
  logic tick_done;
  logic sample_bit;
  logic par_x;
  logic par_bad;

  // Synchronize rx, keep two cycles of history for the vote, and hold off
  // edge detection until the history holds only real line values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rs_q       <= 1'b1;
      rs_prev_q  <= 1'b1;
      rs_prev2_q <= 1'b1;
      settle_q   <= 2'd0;
    end else begin
      rx_meta_q  <= rx;
      rs_q       <= rx_meta_q;
      rs_prev_q  <= rs_q;
      rs_prev2_q <= rs_prev_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // The settle gate stops a line that is already low at reset release from
  // looking like a fresh start edge through the forced-high flops.
  assign rs_fall    = (settle_q == 2'd3) && rs_prev_q && !rs_q;
  assign tick_done  = (tick_q == TICK_ONE);
  assign sample_bit = (rs_q & rs_prev_q) | (rs_q & rs_prev2_q) | (rs_prev_q & rs_prev2_q);
  assign par_x      = par_acc_q ^ sample_bit;
  assign par_bad    = (PARITY == 1) ? ~par_x : par_x;

  // Receive FSM with bit timing, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      perr_pend_q  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      crc_din_q    <= 1'b0;
      crc_en_q     <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      crc_en_q    <= 1'b0;

      if (valid_q && ready) valid_q <= 1'b0;

      // Down-counter reloads on expiry, so samples stay one bit period apart.
      if (state_q != S_IDLE) tick_q <= tick_done ? TICK_FULL : tick_q - TICK_ONE;

      case (state_q)
        S_IDLE: begin
          if (rs_fall) begin
            state_q <= S_START;
            tick_q  <= TICK_HALF;
          end
        end
        S_START: begin
          if (tick_done) begin
            if (sample_bit) begin
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_DATA;
              bit_cnt_q   <= BIT_LAST;
              par_acc_q   <= 1'b0;
              perr_pend_q <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick_done) begin
            shift_q   <= {sample_bit, shift_q[DATA_BITS-1:1]};
            par_acc_q <= par_acc_q ^ sample_bit;
            crc_din_q <= sample_bit;
            crc_en_q  <= 1'b1;
            if (bit_cnt_q == 3'd0) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q - 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick_done) begin
            perr_pend_q <= par_bad;
            state_q     <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick_done) begin
            state_q <= S_IDLE;
            if (!sample_bit) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || ready) begin
              // A same-cycle handshake frees the register, so the new word
              // replaces the consumed one and valid stays up.
              data_q       <= shift_q;
              parity_err_q <= perr_pend_q;
              valid_q      <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign crc_din    = crc_din_q;
  assign crc_en     = crc_en_q;

endmodule

// File: tb/tb_uart_rx2.sv
// Directed bench for uart_rx2: a default-configured receiver and an
// even-parity receiver driven from separate serial lines.
module tb_uart_rx2;

  localparam int CLKS = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, ready;
  logic [7:0] data;
  logic       valid, perr, ferr, ovr, crc_din, crc_en;
  logic       rx_p, ready_p;
  logic [7:0] data_p;
  logic       valid_p, perr_p, ferr_p, ovr_p, crc_din_p, crc_en_p;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  // Monitor state, written only by the monitor process.
  int         cyc = 0;
  int         n_hs = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, valid_rise_cyc = 0;
  logic [7:0] hs_data = 8'h00;
  logic       hs_perr = 1'b0;
  logic       valid_prev = 1'b0;
  int         crc_cyc[$];
  logic       crc_bit[$];
  int         n_hs_p = 0, n_crc_p = 0, n_bad_p = 0;
  logic [7:0] hs_data_p = 8'h00;
  logic       hs_perr_p = 1'b0;

  always #5 clk = ~clk;

  uart_rx2 dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .parity_err(perr), .frame_err(ferr), .overrun(ovr), .crc_din(crc_din), .crc_en(crc_en)
  );

  uart_rx2 #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .data(data_p), .valid(valid_p), .ready(ready_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .crc_din(crc_din_p), .crc_en(crc_en_p)
  );

  // Sample outputs 1ns after each rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (valid === 1'b1) n_vcyc++;
    if (valid === 1'b1 && valid_prev !== 1'b1) valid_rise_cyc = cyc;
    valid_prev = valid;
    if (valid === 1'b1 && ready === 1'b1) begin
      n_hs++;
      hs_data = data;
      hs_perr = perr;
    end
    if (ferr === 1'b1) n_ferr++;
    if (ovr === 1'b1) n_ovr++;
    if (crc_en === 1'b1) begin
      crc_cyc.push_back(cyc);
      crc_bit.push_back(crc_din);
    end
    if (valid_p === 1'b1 && ready_p === 1'b1) begin
      n_hs_p++;
      hs_data_p = data_p;
      hs_perr_p = perr_p;
    end
    if (crc_en_p === 1'b1 && crc_din_p !== 1'bx) n_crc_p++;
    if (ferr_p === 1'b1 || ovr_p === 1'b1) n_bad_p++;
  end

  task automatic drive_bit(input bit sel, input logic v);
    @(negedge clk);
    if (sel) rx_p = v; else rx = v;
    repeat (CLKS - 1) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bit, 2 idle bits.
  task automatic send(input bit sel, input logic [7:0] b, input bit use_par,
                      input logic pbit, input logic sbit);
    @(negedge clk);
    start_cyc = cyc;
    if (sel) rx_p = 1'b0; else rx = 1'b0;
    repeat (CLKS - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    if (use_par) drive_bit(sel, pbit);
    drive_bit(sel, sbit);
    drive_bit(sel, 1'b1);
    drive_bit(sel, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    checks++; if (crc_en !== 1'b0) begin errors++; $display("FAIL reset_crc_en: got %b want 0", crc_en); end
    checks++; if (crc_din !== 1'b0) begin errors++; $display("FAIL reset_crc_din: got %b want 0", crc_din); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Line held low across reset release must not start a frame.
  task automatic test_low_after_reset();
    int c0, f0, v0;
    c0 = crc_bit.size(); f0 = n_ferr; v0 = n_vcyc;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (crc_bit.size() - c0 !== 0) begin errors++; $display("FAIL lowrel_crc: got %0d want 0", crc_bit.size() - c0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL lowrel_ferr: got %0d want 0", n_ferr - f0); end
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL lowrel_valid: got %0d want 0", n_vcyc - v0); end
  endtask

  task automatic test_basic();
    int c0, h0, v0;
    logic [7:0] exp;
    exp = 8'hA5;
    c0 = crc_bit.size(); h0 = n_hs; v0 = n_vcyc;
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", n_hs - h0); end
    checks++; if (hs_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", hs_data); end
    checks++; if (hs_perr !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", hs_perr); end
    // 2 synchronizer cycles to the edge-detect cycle, then 6 + 9*12 + 1.
    checks++; if (valid_rise_cyc - start_cyc !== 117) begin errors++; $display("FAIL basic_latency: got %0d want 117", valid_rise_cyc - start_cyc); end
    checks++; if (n_vcyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_len: got %0d want 1", n_vcyc - v0); end
    checks++; if (crc_bit.size() - c0 !== 8) begin errors++; $display("FAIL basic_crc_count: got %0d want 8", crc_bit.size() - c0); end
    if (crc_bit.size() >= c0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (crc_bit[c0+i] !== exp[i]) begin errors++; $display("FAIL basic_crc_bit%0d: got %b want %b", i, crc_bit[c0+i], exp[i]); end
      end
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (crc_cyc[c0+i] - crc_cyc[c0+i-1] !== CLKS) begin
          errors++; $display("FAIL basic_crc_gap%0d: got %0d want %0d", i, crc_cyc[c0+i] - crc_cyc[c0+i-1], CLKS);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int c0, f0, v0, h0;
    c0 = crc_bit.size(); f0 = n_ferr; v0 = n_vcyc;
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (crc_bit.size() - c0 !== 0) begin errors++; $display("FAIL glitch_crc: got %0d want 0", crc_bit.size() - c0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", n_vcyc - v0); end
    h0 = n_hs;
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d want 1", n_hs - h0); end
    checks++; if (hs_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data: got %h want 3c", hs_data); end
  endtask

  task automatic test_frame_err();
    int f0, v0, h0;
    f0 = n_ferr; v0 = n_vcyc;
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", n_ferr - f0); end
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", n_vcyc - v0); end
    h0 = n_hs;
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", n_hs - h0); end
    checks++; if (hs_data !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %h want 55", hs_data); end
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_next_clean: got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_parity();
    int h0, c0, b0;
    h0 = n_hs_p; c0 = n_crc_p; b0 = n_bad_p;
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    checks++; if (n_hs_p - h0 !== 1) begin errors++; $display("FAIL par_bad_count: got %0d want 1", n_hs_p - h0); end
    checks++; if (hs_data_p !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h want 07", hs_data_p); end
    checks++; if (hs_perr_p !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b want 1", hs_perr_p); end
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    checks++; if (n_hs_p - h0 !== 2) begin errors++; $display("FAIL par_ok_count: got %0d want 2", n_hs_p - h0); end
    checks++; if (hs_data_p !== 8'h07) begin errors++; $display("FAIL par_ok_data: got %h want 07", hs_data_p); end
    checks++; if (hs_perr_p !== 1'b0) begin errors++; $display("FAIL par_ok_perr: got %b want 0", hs_perr_p); end
    checks++; if (n_crc_p - c0 !== 16) begin errors++; $display("FAIL par_crc_count: got %0d want 16", n_crc_p - c0); end
    checks++; if (n_bad_p - b0 !== 0) begin errors++; $display("FAIL par_pulses: got %0d want 0", n_bad_p - b0); end
  endtask

  task automatic test_overrun();
    int o0;
    @(negedge clk); ready = 1'b0;
    o0 = n_ovr;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b want 1", valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h want 11", data); end
    checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL ovr_first_none: got %0d want 0", n_ovr - o0); end
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_held_data: got %h want 11", data); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b want 1", valid); end
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL consume_data: got %h want 11", data); end
  endtask

  task automatic test_reset_mid();
    int c0, f0, v0, h0;
    @(negedge clk); rx = 1'b0;
    repeat (CLKS - 1) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", data); end
    checks++; if (crc_din !== 1'b0) begin errors++; $display("FAIL rmid_crc_din: got %b want 0", crc_din); end
    checks++; if (crc_en !== 1'b0) begin errors++; $display("FAIL rmid_crc_en: got %b want 0", crc_en); end
    checks++; if (ferr !== 1'b0 || ovr !== 1'b0 || perr !== 1'b0) begin
      errors++; $display("FAIL rmid_flags: got %b%b%b want 000", ferr, ovr, perr);
    end
    c0 = crc_bit.size(); f0 = n_ferr; v0 = n_vcyc;
    @(negedge clk); rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (crc_bit.size() - c0 + n_ferr - f0 + n_vcyc - v0 !== 0) begin
      errors++; $display("FAIL rmid_quiet: got %0d events want 0", crc_bit.size() - c0 + n_ferr - f0 + n_vcyc - v0);
    end
    h0 = n_hs;
    send(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL rmid_next_count: got %0d want 1", n_hs - h0); end
    checks++; if (hs_data !== 8'hF0) begin errors++; $display("FAIL rmid_next_data: got %h want f0", hs_data); end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b0;
    rx_p    = 1'b1;
    ready   = 1'b1;
    ready_p = 1'b1;
    test_reset();
    test_low_after_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
